// File: rtl/xex_sector_sequencer.sv
// XEX sector sequencer: drives a shared AES-256 engine through tweak encryption,
// per-block whitening and tweak doubling. Optional tweak cache: XEX_TWEAK_CACHE_EN.
module xex_sector_sequencer #(
  parameter int BLOCKS = 256,
  parameter int CNT_W  = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic         enc_dec,
  input  logic [127:0] sector,
  input  logic         abort,
  input  logic         new_key,
  input  logic         in_valid,
  input  logic [127:0] in_data,
  output logic         in_ready,
  output logic         out_valid,
  output logic [127:0] out_data,
  input  logic         out_ready,
  output logic         busy,
  output logic         done,
  output logic         error,
  output logic         aes_start,
  output logic         aes_enc_dec,
  output logic         aes_key_sel,
  output logic [127:0] aes_in,
  input  logic         aes_ready,
  input  logic [127:0] aes_out,
  output logic [2:0]   dbg_state
);

  // Handshakes: a block moves on in_valid & in_ready and on out_valid & out_ready;
  // out_valid/out_data never change while waiting for out_ready; aes_ready is a pulse.
  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_TWK_REQ  = 3'd1,
    S_TWK_WAIT = 3'd2,
    S_FETCH    = 3'd3,
    S_BLK_REQ  = 3'd4,
    S_BLK_WAIT = 3'd5,
    S_EMIT     = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic               enc_q, enc_d;
  logic [127:0]       t_q, t_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
  logic               out_valid_q, out_valid_d;
  logic [127:0]       out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               error_q, error_d;
  logic               aes_start_q, aes_start_d;
  logic               aes_enc_dec_q, aes_enc_dec_d;
  logic               aes_key_sel_q, aes_key_sel_d;
  logic [127:0]       aes_in_q, aes_in_d;

`ifdef XEX_TWEAK_CACHE_EN
  logic               cache_vld_q, cache_vld_d;
  logic [127:0]       cache_sec_q, cache_sec_d;
  logic [127:0]       cache_t0_q, cache_t0_d;
  logic [127:0]       sector_q, sector_d;
`else
  logic               unused_new_key;
  assign unused_new_key = new_key;
`endif

  // GF(2^128) doubling; T[127:120] is byte 0 of the little-endian field element.
  function automatic logic [127:0] xex_dbl(input logic [127:0] t);
    logic [127:0] l, ls, r;
    for (int i = 0; i < 16; i++) l[i*8 +: 8] = t[(15-i)*8 +: 8];
    ls = {l[126:0], 1'b0} ^ (l[127] ? 128'h87 : 128'h0);
    for (int i = 0; i < 16; i++) r[i*8 +: 8] = ls[(15-i)*8 +: 8];
    return r;
  endfunction

  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    enc_d         = enc_q;
    t_d           = t_q;
    cnt_d         = cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    done_d        = 1'b0;
    error_d       = 1'b0;
    aes_enc_dec_d = aes_enc_dec_q;
    aes_key_sel_d = aes_key_sel_q;
    aes_in_d      = aes_in_q;
`ifdef XEX_TWEAK_CACHE_EN
    cache_vld_d   = cache_vld_q;
    cache_sec_d   = cache_sec_q;
    cache_t0_d    = cache_t0_q;
    sector_d      = sector_q;
`endif

    if (start && state_q != S_IDLE) error_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          enc_d         = enc_dec;
          state_d       = S_TWK_REQ;
          aes_in_d      = sector;
          aes_key_sel_d = 1'b1;
          aes_enc_dec_d = 1'b1;
`ifdef XEX_TWEAK_CACHE_EN
          sector_d      = sector;
          if (cache_vld_q && cache_sec_q == sector) begin
            state_d       = S_FETCH;
            t_d           = cache_t0_q;
            aes_in_d      = aes_in_q;
            aes_key_sel_d = aes_key_sel_q;
            aes_enc_dec_d = aes_enc_dec_q;
          end
`endif
        end
      end
      S_TWK_REQ: state_d = S_TWK_WAIT;
      S_TWK_WAIT: begin
        if (aes_ready) begin
          t_d     = aes_out;
          state_d = S_FETCH;
`ifdef XEX_TWEAK_CACHE_EN
          cache_vld_d = 1'b1;
          cache_sec_d = sector_q;
          cache_t0_d  = aes_out;
`endif
        end
      end
      S_FETCH: begin
        if (in_valid) begin
          aes_in_d      = in_data ^ t_q;
          aes_key_sel_d = 1'b0;
          aes_enc_dec_d = enc_q;
          state_d       = S_BLK_REQ;
        end
      end
      S_BLK_REQ: state_d = S_BLK_WAIT;
      S_BLK_WAIT: begin
        if (aes_ready) begin
          out_data_d  = aes_out ^ t_q;
          out_valid_d = 1'b1;
          t_d         = xex_dbl(t_q);
          state_d     = S_EMIT;
        end
      end
      S_EMIT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (cnt_inc == CNT_W'(BLOCKS)) begin
            done_d  = 1'b1;
            cnt_d   = '0;
            state_d = S_IDLE;
          end else begin
            cnt_d   = cnt_inc;
            state_d = S_FETCH;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything above, including a result landing this cycle.
    if (abort && state_q != S_IDLE) begin
      state_d     = S_IDLE;
      out_valid_d = 1'b0;
      cnt_d       = '0;
      done_d      = 1'b0;
      t_d         = t_q;
`ifdef XEX_TWEAK_CACHE_EN
      if (state_q == S_TWK_WAIT) begin
        cache_vld_d = 1'b0;
        cache_sec_d = cache_sec_q;
        cache_t0_d  = cache_t0_q;
      end
`endif
    end

`ifdef XEX_TWEAK_CACHE_EN
    if (new_key) cache_vld_d = 1'b0;
`endif

    in_ready_d  = (state_d == S_FETCH);
    aes_start_d = (state_d == S_TWK_REQ) || (state_d == S_BLK_REQ);
    busy_d      = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= S_IDLE;
      enc_q         <= 1'b0;
      t_q           <= '0;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      in_ready_q    <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      aes_start_q   <= 1'b0;
      aes_enc_dec_q <= 1'b0;
      aes_key_sel_q <= 1'b0;
      aes_in_q      <= '0;
`ifdef XEX_TWEAK_CACHE_EN
      cache_vld_q   <= 1'b0;
      cache_sec_q   <= '0;
      cache_t0_q    <= '0;
      sector_q      <= '0;
`endif
    end else begin
      state_q       <= state_d;
      enc_q         <= enc_d;
      t_q           <= t_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      in_ready_q    <= in_ready_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
      aes_start_q   <= aes_start_d;
      aes_enc_dec_q <= aes_enc_dec_d;
      aes_key_sel_q <= aes_key_sel_d;
      aes_in_q      <= aes_in_d;
`ifdef XEX_TWEAK_CACHE_EN
      cache_vld_q   <= cache_vld_d;
      cache_sec_q   <= cache_sec_d;
      cache_t0_q    <= cache_t0_d;
      sector_q      <= sector_d;
`endif
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign aes_start   = aes_start_q;
  assign aes_enc_dec = aes_enc_dec_q;
  assign aes_key_sel = aes_key_sel_q;
  assign aes_in      = aes_in_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_xex_sector_sequencer.sv
// Directed bench for xex_sector_sequencer (BLOCKS=2) with an AES stub: aes_out = ~aes_in, 12-cycle latency.
module tb_xex_sector_sequencer;

  logic         clk = 1'b0;
  logic         n_rst = 1'b0;
  logic         start = 1'b0, enc_dec = 1'b0, abort = 1'b0, new_key = 1'b0;
  logic [127:0] sector = '0;
  logic         in_valid = 1'b0;
  logic [127:0] in_data = '0;
  logic         in_ready, out_valid, busy, done, error;
  logic [127:0] out_data;
  logic         out_ready = 1'b0;
  logic         aes_start, aes_enc_dec, aes_key_sel;
  logic [127:0] aes_in;
  logic         aes_ready = 1'b0;
  logic [127:0] aes_out = '0;
  logic [2:0]   dbg_state;

  int checks = 0, errors = 0;
  int done_cnt = 0, err_cnt = 0;
  int stub_cnt = 0;
  logic [127:0] stub_in = '0;
  logic [129:0] req_q[$];
  logic [127:0] exp_q[$];

  localparam logic [127:0] ONES = {128{1'b1}};
  localparam logic [127:0] P0 = 128'h0123456789ABCDEF_FEDCBA9876543210;
  localparam logic [127:0] P1 = 128'hDEADBEEF_00112233_44556677_CAFEF00D;

  always #5 clk = ~clk;

  xex_sector_sequencer #(.BLOCKS(2), .CNT_W(16)) dut (
    .clk(clk), .n_rst(n_rst), .start(start), .enc_dec(enc_dec), .sector(sector),
    .abort(abort), .new_key(new_key), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .busy(busy), .done(done), .error(error), .aes_start(aes_start),
    .aes_enc_dec(aes_enc_dec), .aes_key_sel(aes_key_sel), .aes_in(aes_in),
    .aes_ready(aes_ready), .aes_out(aes_out), .dbg_state(dbg_state)
  );

  // AES stub plus done/error pulse counters, all on the falling edge.
  always @(negedge clk) begin
    aes_ready = 1'b0;
    if (!n_rst) stub_cnt = 0;
    else if (aes_start) begin
      stub_cnt = 12;
      stub_in  = aes_in;
      req_q.push_back({aes_key_sel, aes_enc_dec, aes_in});
    end else if (stub_cnt > 0) begin
      stub_cnt--;
      if (stub_cnt == 0) begin
        aes_ready = 1'b1;
        aes_out   = ~stub_in;
      end
    end
    if (done) done_cnt++;
    if (error) err_cnt++;
  end

  task automatic do_start(input logic [127:0] sec, input logic enc);
    @(negedge clk);
    start = 1'b1; sector = sec; enc_dec = enc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic push_block(input logic [127:0] d, output int tmo);
    tmo = 0; in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 200; i++) begin
      if (in_ready) break;
      @(negedge clk);
    end
    if (!in_ready) tmo = 1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic pop_block(output logic [127:0] d, output int tmo);
    tmo = 0; out_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    if (!out_valid) tmo = 1;
    d = out_data;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_sector(input logic [127:0] sec, input logic enc, input logic [127:0] p0, p1,
                            output logic [127:0] o0, o1, output int tmo, output int done_mid);
    int t;
    tmo = 0;
    do_start(sec, enc);
    push_block(p0, t); tmo += t;
    pop_block(o0, t);  tmo += t;
    @(negedge clk);
    done_mid = done_cnt;
    push_block(p1, t); tmo += t;
    pop_block(o1, t);  tmo += t;
    repeat (3) @(negedge clk);
    while (req_q.size() < 3) req_q.push_back('x);
  endtask

  task automatic test_reset;
    n_rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL reset_busy_ready: got %b%b want 00", busy, in_ready); end
    checks++; if ({out_valid, done, error, aes_start} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {out_valid, done, error, aes_start}); end
    checks++; if (aes_in !== '0 || out_data !== '0) begin errors++; $display("FAIL reset_data: got %h/%h want 0", aes_in, out_data); end
    n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (dbg_state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_idle: got state %0d busy %b want 0 0", dbg_state, busy); end
  endtask

  task automatic test_basic;
    logic [127:0] o0, o1;
    int tmo, dm, base;
    req_q.delete(); exp_q.delete();
    exp_q.push_back(~P0); exp_q.push_back(~P1);
    base = done_cnt;
    run_sector(128'h0, 1'b1, P0, P1, o0, o1, tmo, dm);
    checks++; if (tmo !== 0) begin errors++; $display("FAIL basic_timeout: got %0d want 0", tmo); end
    checks++; if (req_q[0] !== {1'b1, 1'b1, 128'h0}) begin errors++; $display("FAIL basic_tweak_req: got %h want %h", req_q[0], {1'b1, 1'b1, 128'h0}); end
    checks++; if (req_q[1] !== {2'b01, P0 ^ ONES}) begin errors++; $display("FAIL basic_blk0_req: got %h want %h", req_q[1], {2'b01, P0 ^ ONES}); end
    checks++; if (req_q[2] !== {2'b01, P1 ^ {8'h79, {15{8'hFF}}}}) begin errors++; $display("FAIL basic_blk1_req: got %h want %h", req_q[2], {2'b01, P1 ^ {8'h79, {15{8'hFF}}}}); end
    checks++; if (o0 !== exp_q[0]) begin errors++; $display("FAIL basic_out0: got %h want %h", o0, exp_q[0]); end
    checks++; if (o1 !== exp_q[1]) begin errors++; $display("FAIL basic_out1: got %h want %h", o1, exp_q[1]); end
    checks++; if (dm !== base) begin errors++; $display("FAIL basic_done_early: got %0d want %0d", dm, base); end
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL basic_done_once: got %0d want %0d", done_cnt, base + 1); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_doubling;
    logic [127:0] o0, o1, sec;
    int tmo, dm;
    // T = ~sector under the stub; pick sectors giving T = 0100..00 and T = 00..0080.
    sec = {8'hFE, {15{8'hFF}}};
    req_q.delete();
    run_sector(sec, 1'b0, P0, P1, o0, o1, tmo, dm);
    checks++; if (req_q[0] !== {2'b11, sec}) begin errors++; $display("FAIL dbl_a_tweak: got %h want %h", req_q[0], {2'b11, sec}); end
    checks++; if (req_q[1] !== {2'b00, P0 ^ {8'h01, 120'h0}}) begin errors++; $display("FAIL dbl_a_blk0: got %h want %h", req_q[1], {2'b00, P0 ^ {8'h01, 120'h0}}); end
    checks++; if (req_q[2] !== {2'b00, P1 ^ {8'h02, 120'h0}}) begin errors++; $display("FAIL dbl_a_blk1: got %h want %h", req_q[2], {2'b00, P1 ^ {8'h02, 120'h0}}); end
    checks++; if (o1 !== ~P1 || tmo !== 0) begin errors++; $display("FAIL dbl_a_out1: got %h tmo %0d want %h", o1, tmo, ~P1); end
    sec = {{15{8'hFF}}, 8'h7F};
    req_q.delete();
    run_sector(sec, 1'b1, P1, P0, o0, o1, tmo, dm);
    checks++; if (req_q[1] !== {2'b01, P1 ^ 128'h80}) begin errors++; $display("FAIL dbl_b_blk0: got %h want %h", req_q[1], {2'b01, P1 ^ 128'h80}); end
    checks++; if (req_q[2] !== {2'b01, P0 ^ {8'h87, 120'h0}}) begin errors++; $display("FAIL dbl_b_blk1: got %h want %h", req_q[2], {2'b01, P0 ^ {8'h87, 120'h0}}); end
    checks++; if (o0 !== ~P1 || o1 !== ~P0) begin errors++; $display("FAIL dbl_b_out: got %h %h want %h %h", o0, o1, ~P1, ~P0); end
  endtask

  task automatic test_backpressure;
    logic [127:0] o0, o1;
    int tmo, t, bad_v, bad_d, bad_r, bad_s, base;
    base = done_cnt;
    bad_v = 0; bad_d = 0; bad_r = 0; bad_s = 0;
    do_start(128'h1234, 1'b1);
    push_block(P0, tmo);
    for (int i = 0; i < 200; i++) begin
      if (out_valid) break;
      @(negedge clk);
    end
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL bp_reach_emit: got out_valid %b want 1", out_valid); end
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b1) bad_v++;
      if (out_data !== ~P0) bad_d++;
      if (in_ready !== 1'b0) bad_r++;
      if (aes_start !== 1'b0) bad_s++;
    end
    checks++; if (bad_v !== 0) begin errors++; $display("FAIL bp_valid_held: got %0d drops want 0", bad_v); end
    checks++; if (bad_d !== 0) begin errors++; $display("FAIL bp_data_stable: got %0d changes want 0", bad_d); end
    checks++; if (bad_r !== 0) begin errors++; $display("FAIL bp_no_in_ready: got %0d want 0", bad_r); end
    checks++; if (bad_s !== 0) begin errors++; $display("FAIL bp_no_aes_start: got %0d want 0", bad_s); end
    pop_block(o0, t); tmo += t;
    push_block(P1, t); tmo += t;
    pop_block(o1, t);  tmo += t;
    repeat (3) @(negedge clk);
    checks++; if (o1 !== ~P1 || tmo !== 0) begin errors++; $display("FAIL bp_out1: got %h tmo %0d want %h", o1, tmo, ~P1); end
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL bp_done: got %0d want %0d", done_cnt, base + 1); end
  endtask

  task automatic test_abort;
    logic [127:0] o0, o1;
    int tmo, dm, base, seen_v, seen_b;
    base = done_cnt; seen_v = 0; seen_b = 0;
    do_start(128'hA5A5, 1'b1);
    push_block(P0, tmo);
    @(negedge clk);
    checks++; if (dbg_state !== 3'd5) begin errors++; $display("FAIL abort_in_blk_wait: got state %0d want 5", dbg_state); end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checks++; if (busy !== 1'b0 || dbg_state !== 3'd0) begin errors++; $display("FAIL abort_idle: got busy %b state %0d want 0 0", busy, dbg_state); end
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen_v++;
      if (busy) seen_b++;
    end
    checks++; if (seen_v !== 0 || seen_b !== 0) begin errors++; $display("FAIL abort_late_result: got valid %0d busy %0d want 0 0", seen_v, seen_b); end
    checks++; if (done_cnt !== base) begin errors++; $display("FAIL abort_no_done: got %0d want %0d", done_cnt, base); end
    run_sector(128'h5A5A, 1'b1, P1, P0, o0, o1, tmo, dm);
    checks++; if (o0 !== ~P1 || o1 !== ~P0 || tmo !== 0) begin errors++; $display("FAIL abort_restart: got %h %h tmo %0d want %h %h", o0, o1, tmo, ~P1, ~P0); end
    checks++; if (done_cnt !== base + 1) begin errors++; $display("FAIL abort_restart_done: got %0d want %0d", done_cnt, base + 1); end
  endtask

  task automatic test_error;
    logic [127:0] o0, o1, sec;
    int tmo, t, base_e;
    sec = 128'h0F0F_0000_1111;
    base_e = err_cnt;
    req_q.delete();
    do_start(sec, 1'b1);
    repeat (2) @(negedge clk);
    start = 1'b1; sector = 128'h7777;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (err_cnt !== base_e + 1) begin errors++; $display("FAIL error_pulse: got %0d want %0d", err_cnt, base_e + 1); end
    push_block(P0, tmo);
    pop_block(o0, t); tmo += t;
    push_block(P1, t); tmo += t;
    pop_block(o1, t);  tmo += t;
    repeat (3) @(negedge clk);
    while (req_q.size() < 3) req_q.push_back('x);
    checks++; if (req_q[1] !== {2'b01, P0 ^ ~sec}) begin errors++; $display("FAIL error_sector_kept: got %h want %h", req_q[1], {2'b01, P0 ^ ~sec}); end
    checks++; if (req_q.size() !== 3 || tmo !== 0) begin errors++; $display("FAIL error_req_count: got %0d tmo %0d want 3 0", req_q.size(), tmo); end
  endtask

  task automatic test_cache;
    logic [127:0] o0, o1, sec;
    int tmo, dm;
    sec = 128'hC0FFEE;
    req_q.delete();
    run_sector(sec, 1'b1, P0, P1, o0, o1, tmo, dm);
    checks++; if (req_q[0] !== {2'b11, sec}) begin errors++; $display("FAIL cache_first_tweak: got %h want %h", req_q[0], {2'b11, sec}); end
    req_q.delete();
    run_sector(sec, 1'b1, P0, P1, o0, o1, tmo, dm);
`ifdef XEX_TWEAK_CACHE_EN
    checks++; if (req_q[0] !== {2'b01, P0 ^ ~sec}) begin errors++; $display("FAIL cache_hit_skip: got %h want %h", req_q[0], {2'b01, P0 ^ ~sec}); end
`else
    checks++; if (req_q[0] !== {2'b11, sec}) begin errors++; $display("FAIL cache_off_tweak: got %h want %h", req_q[0], {2'b11, sec}); end
`endif
    checks++; if (o0 !== ~P0 || o1 !== ~P1 || tmo !== 0) begin errors++; $display("FAIL cache_repeat_out: got %h %h tmo %0d", o0, o1, tmo); end
    @(negedge clk); new_key = 1'b1;
    @(negedge clk); new_key = 1'b0;
    req_q.delete();
    run_sector(sec, 1'b1, P0, P1, o0, o1, tmo, dm);
    checks++; if (req_q[0] !== {2'b11, sec}) begin errors++; $display("FAIL cache_new_key: got %h want %h", req_q[0], {2'b11, sec}); end
  endtask

  task automatic test_reset_mid;
    int tmo;
    do_start(128'hBEEF, 1'b1);
    push_block(P0, tmo);
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b1 || aes_in === '0) begin errors++; $display("FAIL rst_mid_active: got busy %b aes_in %h", busy, aes_in); end
    #2 n_rst = 1'b0;
    #1;
    checks++; if ({busy, in_ready, out_valid, done, error, aes_start, aes_key_sel} !== 7'b0) begin errors++; $display("FAIL rst_mid_flags: got %b want 0", {busy, in_ready, out_valid, done, error, aes_start, aes_key_sel}); end
    checks++; if (aes_in !== '0 || out_data !== '0 || dbg_state !== 3'd0) begin errors++; $display("FAIL rst_mid_data: got %h %h %0d want 0", aes_in, out_data, dbg_state); end
    @(negedge clk); n_rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_release: got busy %b in_ready %b want 0 0", busy, in_ready); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_basic;
    test_doubling;
    test_backpressure;
    test_abort;
    test_error;
    test_cache;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
